// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two bypassed combinational read ports and a
// per-register busy scoreboard; a post-reset clear engine zeroes the array one entry per cycle.
module regfile_scoreboard #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            we,
    input  logic [AW-1:0]   wr_addr,
    input  logic [XLEN-1:0] wr_data,
    input  logic            iss_valid,
    input  logic [AW-1:0]   iss_rd,
    output logic            stall,
    output logic            ready
);

    localparam int NREGS = 2 ** AW;
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              ready_q, ready_d;
    logic [NREGS-1:0]  busy_q, busy_d;
    logic [XLEN-1:0]   rf_q [NREGS];

    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              run, wr_fire, accept;
    logic              byp1, byp2, bypd;
    logic              hz1, hz2, hzd;

    // Control state; the array itself carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_idx_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rf_we) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        ready_d   = ready_q;
        case (state_q)
            ST_INIT: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    ready_d = 1'b1;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_comb begin
        run     = (state_q == ST_RUN);
        wr_fire = run && we && (wr_addr != '0);

        // A write landing this cycle resolves the hazard on its own target.
        byp1 = we && (wr_addr == rs1_addr);
        byp2 = we && (wr_addr == rs2_addr);
        bypd = we && (wr_addr == iss_rd);
        hz1  = busy_q[rs1_addr] && (rs1_addr != '0) && !byp1;
        hz2  = busy_q[rs2_addr] && (rs2_addr != '0) && !byp2;
        hzd  = busy_q[iss_rd]   && (iss_rd   != '0) && !bypd;

        stall  = !ready_q || (iss_valid && (hz1 || hz2 || hzd));
        accept = run && iss_valid && !stall;
        ready  = ready_q;

        if (!run || rs1_addr == '0) begin
            rs1_data = '0;
        end else if (byp1) begin
            rs1_data = wr_data;
        end else begin
            rs1_data = rf_q[rs1_addr];
        end

        if (!run || rs2_addr == '0) begin
            rs2_data = '0;
        end else if (byp2) begin
            rs2_data = wr_data;
        end else begin
            rs2_data = rf_q[rs2_addr];
        end

        if (!run) begin
            rf_we    = 1'b1;
            rf_waddr = clr_idx_q;
            rf_wdata = '0;
        end else begin
            rf_we    = wr_fire;
            rf_waddr = wr_addr;
            rf_wdata = wr_data;
        end

        // Set is applied after clear so a coincident set wins.
        busy_d = busy_q;
        if (wr_fire) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (accept && iss_rd != '0) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: the driver queues expected outputs per cycle,
// a monitor on the falling edge pops and compares them.
module tb_regfile_scoreboard;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int NREGS = 2 ** AW;

    localparam int SEL_RS1   = 0;
    localparam int SEL_RS2   = 1;
    localparam int SEL_STALL = 2;
    localparam int SEL_READY = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, iss_rd;
    logic [XLEN-1:0] rs1_data, rs2_data, wr_data;
    logic            we, iss_valid, stall, ready;

    logic [XLEN-1:0] exp_q[$];
    int              sel_q[$];
    string           name_q[$];
    int              vectors = 0;
    int              miscompares = 0;
    int              cyc = 0;

    regfile_scoreboard #(.XLEN(XLEN), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .stall(stall), .ready(ready)
    );

    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_out(input int sel, input logic [XLEN-1:0] v, input string nm);
        sel_q.push_back(sel);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic idle();
        we = 1'b0; iss_valid = 1'b0;
        wr_addr = '0; wr_data = '0; iss_rd = '0;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    // Monitor: outputs are stable by the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                int              s;
                logic [XLEN-1:0] e, a;
                string           n;
                s = sel_q.pop_front();
                e = exp_q.pop_front();
                n = name_q.pop_front();
                case (s)
                    SEL_RS1:   a = rs1_data;
                    SEL_RS2:   a = rs2_data;
                    SEL_STALL: a = {{(XLEN-1){1'b0}}, stall};
                    default:   a = {{(XLEN-1){1'b0}}, ready};
                endcase
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL %s (cycle %0d): got %h expected %h", n, cyc, a, e);
                end
            end
        end
    end

    initial begin
        idle();
        rst = 1'b1;
        cycle();
        expect_out(SEL_READY, 0, "reset_ready");
        expect_out(SEL_STALL, 1, "reset_stall");
        expect_out(SEL_RS1,   0, "reset_rs1");
        cycle();
        rst = 1'b0;

        // Init: 32 cycles of ready=0/stall=1 with reads forced to zero.
        for (int k = 0; k < NREGS; k++) begin
            rs1_addr = AW'(k);
            expect_out(SEL_READY, 0, "init_ready_low");
            expect_out(SEL_STALL, 1, "init_stall_high");
            expect_out(SEL_RS1,   0, "init_rs1_zero");
            cycle();
        end
        expect_out(SEL_READY, 1, "init_ready_rise");
        expect_out(SEL_STALL, 0, "init_stall_drop");
        for (int k = 0; k < NREGS; k++) begin
            rs1_addr = AW'(k);
            expect_out(SEL_RS1, 0, "cleared_rs1");
            cycle();
        end

        // Bypass then stored value.
        we = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; rs1_addr = 5;
        expect_out(SEL_RS1, 32'hDEADBEEF, "bypass_same_cycle");
        cycle();
        we = 1'b0;
        expect_out(SEL_RS1, 32'hDEADBEEF, "write_stored");
        cycle();

        // Zero register.
        we = 1'b1; wr_addr = 0; wr_data = 32'h1234; rs1_addr = 0;
        expect_out(SEL_RS1, 0, "zero_write_discarded");
        cycle();
        we = 1'b0; iss_valid = 1'b1; iss_rd = 0;
        expect_out(SEL_RS1,   0, "zero_read");
        expect_out(SEL_STALL, 0, "zero_issue");
        cycle();
        expect_out(SEL_STALL, 0, "zero_never_busy");
        cycle();

        // RAW on entry 7.
        iss_rd = 7; rs1_addr = 0; rs2_addr = 0;
        expect_out(SEL_STALL, 0, "raw_producer_accept");
        cycle();
        iss_rd = 8; rs2_addr = 7;
        expect_out(SEL_STALL, 1, "raw_stall_1");
        cycle();
        expect_out(SEL_STALL, 1, "raw_stall_2");
        cycle();
        we = 1'b1; wr_addr = 7; wr_data = 32'h55;
        expect_out(SEL_STALL, 0, "raw_release");
        expect_out(SEL_RS2,   32'h55, "raw_bypass_data");
        cycle();
        idle();
        cycle();

        // WAW on entry 9.
        iss_valid = 1'b1; iss_rd = 9;
        expect_out(SEL_STALL, 0, "waw_first_accept");
        cycle();
        expect_out(SEL_STALL, 1, "waw_stall_1");
        cycle();
        expect_out(SEL_STALL, 1, "waw_stall_2");
        cycle();
        we = 1'b1; wr_addr = 9; wr_data = 32'h99;
        expect_out(SEL_STALL, 0, "waw_accept_on_write");
        cycle();
        we = 1'b0; iss_rd = 10; rs1_addr = 9;
        expect_out(SEL_STALL, 1, "waw_busy_again");
        expect_out(SEL_RS1,   32'h99, "waw_data");
        cycle();
        idle();
        cycle();

        // Busy 3, write 4, then reset mid-run.
        iss_valid = 1'b1; iss_rd = 3;
        expect_out(SEL_STALL, 0, "mid_issue_3");
        cycle();
        iss_valid = 1'b0; we = 1'b1; wr_addr = 4; wr_data = 32'hFF;
        cycle();
        we = 1'b0; rs1_addr = 4; iss_valid = 1'b1; iss_rd = 11; rs2_addr = 3;
        expect_out(SEL_RS1,   32'hFF, "mid_entry4");
        expect_out(SEL_STALL, 1, "mid_busy3");
        cycle();
        idle();
        while (cyc < 100) cycle();
        rst = 1'b1;
        expect_out(SEL_READY, 1, "mid_ready_before_rst");
        cycle();
        rst = 1'b0;
        expect_out(SEL_READY, 0, "mid_ready_drop");
        expect_out(SEL_STALL, 1, "mid_stall_high");
        for (int k = 0; k < NREGS; k++) cycle();
        expect_out(SEL_READY, 1, "reinit_ready");
        rs1_addr = 4;
        expect_out(SEL_RS1, 0, "reinit_entry4_zero");
        cycle();
        iss_valid = 1'b1; iss_rd = 12; rs1_addr = 3; rs2_addr = 8;
        expect_out(SEL_STALL, 0, "reinit_busy_cleared");
        cycle();
        idle();
        cycle();

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
